// File: rtl/syn_fifo_fwft_if.sv
// Handshake/status bundle for syn_fifo_fwft.
//   master : producer/consumer side (drives w_en, w_data, r_en, clr_err)
//   slave  : the FIFO itself (drives read data, status flags and counts)
interface syn_fifo_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  is_empty;
    logic                  is_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   data_avail;
    logic [ADDR_WIDTH:0]   room_avail;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, w_data, r_en, clr_err,
        input  r_data, r_valid, is_empty, is_full, almost_empty, almost_full,
               data_avail, room_avail, overflow, underflow
    );

    modport slave (
        input  w_en, w_data, r_en, clr_err,
        output r_data, r_valid, is_empty, is_full, almost_empty, almost_full,
               data_avail, room_avail, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_fwft.sv
// Synchronous FIFO with selectable read style.
//   FWFT=0 : r_en requests a word; r_data/r_valid are registered and valid
//            the cycle after acceptance; r_data holds otherwise.
//   FWFT=1 : head word is presented on r_data with r_valid=1 unrequested;
//            r_en pops it. The presented word still counts in data_avail.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - syn_fifo_fwft_if.slave: write/read requests, read data,
//          registered status (empty/full/almost flags, counts, sticky errors)
module syn_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (2**ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input logic            clk,
    input logic            rst,
    syn_fifo_fwft_if.slave bus
);
    localparam int FIFO_DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full/empty never alias.
    logic [ADDR_WIDTH:0]   w_ptr, r_ptr;
    logic [ADDR_WIDTH:0]   count, room, count_nxt;
    logic                  empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rv_q;
    logic                  wr_acc, rd_acc, mem_rd;

    // Flags are the registered pre-edge view, so a write into a full FIFO is
    // rejected even when a read is accepted in the same cycle.
    assign wr_acc = bus.w_en & ~full_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // Pop acknowledges the presented word. The output register is
            // refilled from the array whenever it is free or being popped,
            // so back-to-back pops see no r_valid gap.
            assign rd_acc = bus.r_en & rv_q;
            assign mem_rd = (~rv_q | rd_acc) & (w_ptr != r_ptr);
        end else begin : g_std
            assign rd_acc = bus.r_en & ~empty_q;
            assign mem_rd = rd_acc;
        end
    endgenerate

    // count tracks every stored word, including one parked in the FWFT
    // output register, so capacity is FIFO_DEPTH in both modes.
    assign count_nxt = count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);

    // Array is not reset: stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[w_ptr[ADDR_WIDTH-1:0]] <= bus.w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            room    <= DEPTH_C;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_C == '0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rd_q    <= '0;
            rv_q    <= 1'b0;
        end else begin
            w_ptr   <= w_ptr + (ADDR_WIDTH+1)'(wr_acc);
            r_ptr   <= r_ptr + (ADDR_WIDTH+1)'(mem_rd);
            // Status registered from next-state so it lines up with pointers.
            count   <= count_nxt;
            room    <= DEPTH_C - count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
            ae_q    <= (count_nxt <= AE_C);
            af_q    <= (count_nxt >= AF_C);
            // A fresh error wins over a same-cycle clear.
            ovf_q   <= (bus.w_en & full_q)  | (ovf_q & ~bus.clr_err);
            unf_q   <= (bus.r_en & empty_q) | (unf_q & ~bus.clr_err);
            if (mem_rd)
                rd_q <= mem[r_ptr[ADDR_WIDTH-1:0]];
            if (FWFT != 0)
                rv_q <= mem_rd | (rv_q & ~rd_acc);
            else
                rv_q <= rd_acc;
        end
    end

    assign bus.r_data       = rd_q;
    assign bus.r_valid      = rv_q;
    assign bus.is_empty     = empty_q;
    assign bus.is_full      = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.data_avail   = count;
    assign bus.room_avail   = room;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
